// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: constants shared with the CPU interrupt vector logic
package interrupt_controller_pkg;
  localparam int N_INTS = 256;
  localparam int INT_ID_W = 8;
  typedef logic [INT_ID_W-1:0] int_id_t;
endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: request lines, enable and registered result bundle
interface interrupt_controller_if
  import interrupt_controller_pkg::*;
#(
  parameter int N_INTS = interrupt_controller_pkg::N_INTS,
  parameter int ID_W = INT_ID_W
);
  logic [N_INTS-1:0] ints;
  logic enable;
  logic available;
  logic [ID_W-1:0] dev_id;
  modport master (output ints, output enable, input available, input dev_id);
  modport slave (input ints, input enable, output available, output dev_id);
endinterface

// File: rtl/ic_prio_enc.sv
// ic_prio_enc: log-depth MSB priority encoder; upper half wins when it has any bit set
module ic_prio_enc #(
  parameter int W = 256
) (
  input  logic [W-1:0]         i_in,
  output logic                 o_any,
  output logic [$clog2(W)-1:0] o_idx
);
  if (W == 2) begin : g_leaf2
    assign o_any = |i_in;
    assign o_idx = i_in[1];
  end else if (W == 4) begin : g_leaf4
    assign o_any = |i_in;
    assign o_idx = i_in[3] ? 2'd3 : i_in[2] ? 2'd2 : i_in[1] ? 2'd1 : 2'd0;
  end else begin : g_tree
    localparam int H = W / 2;
    logic                 w_lo_any, w_hi_any;
    logic [$clog2(H)-1:0] w_lo_idx, w_hi_idx;
    ic_prio_enc #(.W(H)) u_lo (.i_in(i_in[H-1:0]), .o_any(w_lo_any), .o_idx(w_lo_idx));
    ic_prio_enc #(.W(H)) u_hi (.i_in(i_in[W-1:H]), .o_any(w_hi_any), .o_idx(w_hi_idx));
    assign o_any = w_lo_any | w_hi_any;
    assign o_idx = w_hi_any ? {1'b1, w_hi_idx} : {1'b0, w_lo_idx};
  end
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: fixed-priority (highest index wins) encoder with enable-gated output register
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int N_INTS = interrupt_controller_pkg::N_INTS,
  parameter int ID_W = INT_ID_W
) (
  input logic clk,
  input logic rst,
  interrupt_controller_if.slave bus
);
  logic            w_any;
  logic [ID_W-1:0] w_idx;
  logic            r_available = 1'b0;
  logic [ID_W-1:0] r_dev_id = '0;
  ic_prio_enc #(.W(N_INTS)) u_enc (.i_in(bus.ints), .o_any(w_any), .o_idx(w_idx));
  // enable low freezes the last captured result; reset overrides enable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_available <= 1'b0;
      r_dev_id <= '0;
    end else if (bus.enable) begin
      r_available <= w_any;
      r_dev_id <= w_idx;
    end
  end
  assign bus.available = r_available;
  assign bus.dev_id = r_dev_id;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed plan plus randomized traffic against a behavioural model
module tb_interrupt_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic exp_avail = 1'b0;
  logic [7:0] exp_id = '0;
  interrupt_controller_if #(.N_INTS(256), .ID_W(8)) bus ();
  interrupt_controller #(.N_INTS(256), .ID_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] top_bit(input logic [255:0] v);
    logic [7:0] r = 0;
    for (int i = 0; i < 256; i++) if (v[i]) r = 8'(i);
    return r;
  endfunction
  task automatic cyc(input string tag, input logic r, input logic e, input logic [255:0] v);
    rst = r;
    bus.enable = e;
    bus.ints = v;
    @(posedge clk);
    #1;
    if (r) begin
      exp_avail = 1'b0;
      exp_id = '0;
    end else if (e) begin
      exp_avail = |v;
      exp_id = top_bit(v);
    end
    check({tag, ".available"}, 32'(bus.available), 32'(exp_avail));
    check({tag, ".dev_id"}, 32'(bus.dev_id), 32'(exp_id));
  endtask
  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  initial begin
    logic [255:0] v;
    logic [255:0] one;
    int k;
    bus.ints = '0;
    bus.enable = 1'b0;
    #1;
    check("powerup.available", 32'(bus.available), 0);
    check("powerup.dev_id", 32'(bus.dev_id), 0);
    cyc("reset", 1'b1, 1'b0, '0);
    cyc("idle", 1'b0, 1'b1, '0);
    v = '0;
    v[0] = 1'b1;
    v[3] = 1'b1;
    cyc("prio", 1'b0, 1'b1, v);
    v[3] = 1'b0;
    cyc("freeze", 1'b0, 1'b0, v);
    check("freeze.held_id", 32'(bus.dev_id), 3);
    cyc("freeze_clear", 1'b0, 1'b0, '0);
    cyc("reenable", 1'b0, 1'b1, v);
    check("reenable.id0", 32'(bus.dev_id), 0);
    for (int i = 0; i < 8; i++) begin
      v = rand_vec();
      v[255] = 1'b1;
      cyc("top255", 1'b0, 1'b1, v);
    end
    one = 256'd1;
    for (int i = 0; i < 256; i++) begin
      cyc("walk", 1'b0, 1'b1, one << i);
      check("walk.pos", 32'(bus.dev_id), i);
    end
    v = rand_vec();
    v[100] = 1'b1;
    cyc("rst_wins", 1'b1, 1'b1, v);
    cyc("after_rst", 1'b0, 1'b1, v);
    for (int n = 0; n < 3000; n++) begin
      k = int'($urandom_range(3, 0));
      v = rand_vec();
      if (k == 0) v = '0;
      else if (k == 1) v = one << $urandom_range(255, 0);
      else if (k == 2) v = v & ((one << $urandom_range(255, 0)) - 256'd1);
      cyc("rand", $urandom_range(31, 0) == 0, $urandom_range(3, 0) != 0, v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Fixed-priority interrupt controller. It samples 256 level-sensitive interrupt request lines and reports whether any request is pending, plus the index of the highest-numbered active line. It sits between peripheral interrupt sources and the CPU core's interrupt entry logic. The CPU can freeze the reported result by deasserting `enable`.

## Interface
Parameters:
- `N_INTS`, default 256: number of interrupt request lines.
- `ID_W`, default 8: width of `dev_id`; must equal clog2(`N_INTS`).

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `ints`, input, `N_INTS`: interrupt request lines, level-sensitive, bit i = device i.
- `enable`, input, 1: when high, outputs track `ints`; when low, outputs hold.
- `available`, output, 1: registered; high when at least one request was active at the last enabled sample.
- `dev_id`, output, `ID_W`: registered; index of the highest-numbered active request at the last enabled sample.

## Operation
- Priority: the highest index wins. With bits 0 and 3 set, `dev_id` = 3.
- Combinational stage:
  - any = OR-reduce of `ints`.
  - idx = position of the most-significant set bit of `ints`.
  - idx = 0 when `ints` = 0.
- Register stage, evaluated at each rising `clk`:
  - `rst`=1: `available` <= 0, `dev_id` <= 0. Reset takes precedence over `enable`.
  - `rst`=0, `enable`=1: `available` <= any, `dev_id` <= idx.
  - `rst`=0, `enable`=0: both outputs hold their current values, even if `ints` changes or clears.
- No internal latching of requests. A pulse that is not present at an enabled sampling edge is lost. Sources must hold their line until serviced.
- No acknowledge or clear input. A request disappears from the outputs only when its source drops the line and the block is enabled for one edge.
- `dev_id` is only meaningful while `available`=1. When `available`=0, `dev_id` is 0.
- Power-up: outputs are 0 before the first clock edge (register initial value 0), in addition to the reset value.

## Timing
- Latency: one cycle. `ints` stable before edge k, with `enable`=1 at edge k, gives outputs valid after edge k.
- Outputs are purely registered, with no combinational path from `ints` or `enable` to the outputs.
- `enable` is sampled at the same edge as `ints`. Deasserting `enable` before an edge freezes the values captured at the previous enabled edge.
- Re-enabling: the first enabled edge reflects the current `ints`, not any history accumulated while disabled.
- Simultaneous changes:
  - `ints` changing at the same edge that `enable` rises: the new `ints` is captured.
  - `rst` and `enable` both high: reset wins.
- Reset mid-operation clears both outputs at that edge. The next enabled edge resamples.
- Critical path: a 256-bit priority encoder. Build it as a log-depth tree so that it closes timing at the core clock.

## Structure
- Shared package constants: `N_INTS`=256 and `INT_ID_W`=8, reused by the CPU's interrupt vector logic.
- Sub-module `ic_prio_enc`:
  - Parameterizable width.
  - Outputs the any flag and the MSB index.
  - Implemented recursively as a tree: each level combines two half-width results; the upper half wins when its any flag is set.
  - Leaves are 2-bit or 4-bit encoders.
- Top level: one `ic_prio_enc` instance plus the reset and enable output register.

## Test plan
- Start-up: check before and after `rst`, with `ints`=0 -> `available`=0 and `dev_id`=0.
- Idle: `enable`=1, `ints`=0 for one edge -> `available`=0.
- Priority: set `ints[0]` and `ints[3]`, `enable`=1, one edge -> `available`=1, `dev_id`=3.
- Freeze: then clear `ints[3]` and set `enable`=0, one edge -> `available`=1 and `dev_id`=3 (held).
- Re-enable: `enable`=1, one edge -> `available`=1, `dev_id`=0.
- Extremes:
  - `ints[255]` plus random lower bits -> `dev_id`=255.
  - Walking single bit across all 256 positions -> `dev_id` equals the bit position.
  - `rst`=1 with `enable`=1 and `ints` nonzero -> outputs 0.
